// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between an instruction-fetch port (I) and a
//   load/store port (D). One transaction runs at a time. When both ports
//   request together, the port that was not granted last time wins.
//
// Ports
//   CLK, RST                       clock (rising edge), async active-high reset
//   i_valid, i_addr                fetch request and byte address
//   i_ready, i_rdata               fetch completion pulse and fetched word
//   d_valid, d_we, d_addr,
//   d_wdata, d_wstrb               load/store request and payload
//   d_ready, d_rdata               data completion pulse and load word
//   mem_valid, mem_we, mem_addr,
//   mem_wdata, mem_wstrb           request to the unified memory
//   mem_ready, mem_rdata           memory completion and read data
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; arbitrates and registers the winner
// MEM   | memory request held stable until mem_ready
// DONE  | one-cycle ready pulse to the winner
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                i_valid,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_ready,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_valid,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_ready,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_valid,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int SW = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              gnt_d_q, gnt_d_d;     // current winner is the D port
   logic              last_d_q, last_d_d;   // last grant went to the D port
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [SW-1:0]     wstrb_q, wstrb_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              pick_d;

   // D wins when alone, or on a tie when I was granted last.
   assign pick_d = d_valid & (~i_valid | ~last_d_q);

   // state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_valid || d_valid) state_d = MEM;
         MEM:     if (mem_ready) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // grant and payload capture
   always_comb begin
      gnt_d_d   = gnt_d_q;
      last_d_d  = last_d_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      if (state_q == IDLE && (i_valid || d_valid)) begin
         gnt_d_d  = pick_d;
         last_d_d = pick_d;
         if (pick_d) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            wstrb_d = d_we ? d_wstrb : '0;
         end else begin
            // fetches are always word aligned
            addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
            we_d    = 1'b0;
            wdata_d = '0;
            wstrb_d = '0;
         end
      end
      if (state_q == MEM && mem_ready) begin
         if (gnt_d_q) d_rdata_d = mem_rdata;
         else         i_rdata_d = mem_rdata;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         gnt_d_q   <= 1'b0;
         last_d_q  <= 1'b1;    // fetch wins the first tie
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         gnt_d_q   <= gnt_d_d;
         last_d_q  <= last_d_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // outputs; mem_valid decodes straight from state so reset drops it at once
   always_comb begin
      mem_valid = (state_q == MEM);
      mem_we    = we_q & (state_q == MEM);
      mem_wstrb = (state_q == MEM) ? wstrb_q : '0;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      i_ready   = (state_q == DONE) & ~gnt_d_q;
      d_ready   = (state_q == DONE) &  gnt_d_q;
      i_rdata   = i_rdata_q;
      d_rdata   = d_rdata_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        CLK, RST;
   logic        i_valid, i_ready;
   logic [31:0] i_addr, i_rdata;
   logic        d_valid, d_we, d_ready;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wstrb;
   logic        mem_valid, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .CLK(CLK), .RST(RST),
      .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        iv, dv;
      logic [31:0] ia;
      logic        dwe;
      logic [31:0] da, dwd;
      logic [3:0]  dws;
      int          waits;
      logic [31:0] rdata;
      logic        side_d;
      logic [31:0] ea;
      logic        ewe;
      logic [3:0]  ews;
   } vec_t;

   typedef struct {
      logic        side_d;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[5];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Serve one transaction from an IDLE negedge with the request already driven;
   // returns at the IDLE negedge following the DONE cycle.
   task automatic serve(input int waits, input logic [31:0] rd);
      exp_t e;
      int   n;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      @(negedge CLK);
      n = 0;
      while (!mem_valid && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk("grant_latency", n, 0);
      for (int k = 0; k <= waits; k++) begin
         chk("mem_valid", {31'd0, mem_valid}, 32'd1);
         chk("mem_addr", mem_addr, e.addr);
         chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
         chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
         if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
         chk("ready_in_mem", {30'd0, i_ready, d_ready}, 32'd0);
         mem_ready = (k == waits);
         mem_rdata = (k == waits) ? rd : ~rd;
         @(negedge CLK);
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      chk("mem_valid_done", {31'd0, mem_valid}, 32'd0);
      chk("i_ready_done", {31'd0, i_ready}, {31'd0, ~e.side_d});
      chk("d_ready_done", {31'd0, d_ready}, {31'd0, e.side_d});
      if (e.side_d) chk("d_rdata", d_rdata, rd);
      else          chk("i_rdata", i_rdata, rd);
      @(negedge CLK);
      chk("ready_after", {30'd0, i_ready, d_ready}, 32'd0);
      if (e.side_d) chk("d_rdata_hold", d_rdata, rd);
      else          chk("i_rdata_hold", i_rdata, rd);
   endtask

   task automatic push(input logic sd, input logic [31:0] a, input logic we,
                       input logic [3:0] ws, input logic [31:0] wd);
      exp_t e;
      e.side_d = sd; e.addr = a; e.we = we; e.wstrb = ws; e.wdata = wd;
      sb.push_back(e);
   endtask

   initial begin
      //          iv    dv    i_addr         we    d_addr         d_wdata        wstrb waits rdata          side  exp_addr       ewe   ews
      vecs[0] = '{1'b1, 1'b0, 32'h0000_0006, 1'b0, 32'h0,         32'h0,         4'h0, 0,    32'h0050_0093, 1'b0, 32'h0000_0004, 1'b0, 4'h0};
      vecs[1] = '{1'b0, 1'b1, 32'h0,         1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 3,    32'h1234_5678, 1'b1, 32'h0000_0100, 1'b1, 4'hF};
      vecs[2] = '{1'b0, 1'b1, 32'h0,         1'b0, 32'h0000_0203, 32'h5555_5555, 4'h1, 1,    32'h0000_00A5, 1'b1, 32'h0000_0203, 1'b0, 4'h0};
      vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h0,         4'h0, 2,    32'hCAFE_F00D, 1'b0, 32'hFFFF_FFFC, 1'b0, 4'h0};
      vecs[4] = '{1'b0, 1'b1, 32'h0,         1'b1, 32'h0000_0007, 32'hA1B2_C3D4, 4'h6, 0,    32'h0BAD_0BAD, 1'b1, 32'h0000_0007, 1'b1, 4'h6};

      RST = 1'b1;
      i_valid = 0; i_addr = 0; d_valid = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
      mem_ready = 0; mem_rdata = 0;
      repeat (2) @(negedge CLK);
      chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_we_wstrb", {27'd0, mem_we, mem_wstrb}, 32'd0);
      chk("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      RST = 1'b0;

      // table-driven single-requester transactions
      for (int v = 0; v < 5; v++) begin
         i_valid = vecs[v].iv; i_addr = vecs[v].ia;
         d_valid = vecs[v].dv; d_we = vecs[v].dwe; d_addr = vecs[v].da;
         d_wdata = vecs[v].dwd; d_wstrb = vecs[v].dws;
         push(vecs[v].side_d, vecs[v].ea, vecs[v].ewe, vecs[v].ews, vecs[v].dwd);
         serve(vecs[v].waits, vecs[v].rdata);
         i_valid = 0; d_valid = 0;
      end

      // spurious mem_ready while idle
      mem_ready = 1'b1; mem_rdata = 32'hFFFF_0000;
      repeat (2) begin
         @(negedge CLK);
         chk("spur_mem_valid", {31'd0, mem_valid}, 32'd0);
         chk("spur_ready", {30'd0, i_ready, d_ready}, 32'd0);
         chk("spur_i_rdata", i_rdata, 32'hCAFE_F00D);
         chk("spur_d_rdata", d_rdata, 32'h0BAD_0BAD);
      end
      mem_ready = 1'b0;

      // fetch still served with minimum latency after the spurious pulses
      i_valid = 1; i_addr = 32'h0000_0013;
      push(1'b0, 32'h0000_0010, 1'b0, 4'h0, 32'h0);
      serve(0, 32'h0000_0013);
      i_valid = 0;

      // reset asynchronously during a fetch wait state (last grant = I)
      i_valid = 1; i_addr = 32'h0000_0040;
      @(negedge CLK);
      chk("abort_mem_valid", {31'd0, mem_valid}, 32'd1);
      @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      chk("abort_mem_valid_async", {31'd0, mem_valid}, 32'd0);
      chk("abort_mem_addr", mem_addr, 32'd0);
      @(negedge CLK);
      RST = 1'b0; i_valid = 0;
      repeat (3) begin
         @(negedge CLK);
         chk("abort_no_ready", {30'd0, i_ready, d_ready}, 32'd0);
         chk("abort_mem_valid_idle", {31'd0, mem_valid}, 32'd0);
      end
      chk("abort_i_rdata", i_rdata, 32'd0);

      // held tie: fetch, data, fetch
      i_valid = 1; i_addr = 32'h0000_1002;
      d_valid = 1; d_we = 0; d_addr = 32'h0000_2001; d_wdata = 32'h0; d_wstrb = 4'h3;
      push(1'b0, 32'h0000_1000, 1'b0, 4'h0, 32'h0);
      push(1'b1, 32'h0000_2001, 1'b0, 4'h0, 32'h0);
      push(1'b0, 32'h0000_1000, 1'b0, 4'h0, 32'h0);
      serve(0, 32'h1111_1111);
      serve(1, 32'h2222_2222);
      serve(0, 32'h3333_3333);
      i_valid = 0; d_valid = 0;
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
